// File: rtl/axi_llc_pkg.sv
// Shared LLC definitions: port indexing and the two-port round-robin selection helper.
package axi_llc_pkg;

  localparam int unsigned ARB_NUM_PORTS = 2;

  typedef logic port_idx_t;

  // A lone requester wins outright; on a tie the round-robin pointer decides.
  function automatic port_idx_t arb_select(input logic [ARB_NUM_PORTS-1:0] req,
                                           input port_idx_t rr);
    port_idx_t sel;
    if (&req) begin
      sel = rr;
    end else if (req[1]) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/axi_llc_scrub_sched.sv
// Periodic ECC scrub scheduler: free-running period counter plus a sticky pending flag
// released on the first idle SRAM cycle. Only built under AXI_LLC_SRAM_ARB_SCRUB_EN.
module axi_llc_scrub_sched #(
  parameter int unsigned ScrubPeriod = 1024,
  localparam int unsigned CntWidth = (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle,
  output logic trigger
);

  logic [CntWidth-1:0] cnt_q;
  logic                pending_q;
  logic                wrap;

  assign wrap    = (cnt_q == CntWidth'(ScrubPeriod - 1));
  assign trigger = pending_q & idle;

  // A wrap coinciding with a trigger re-arms, so no period is ever lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CntWidth'(1);
      if (wrap) begin
        pending_q <= 1'b1;
      end else if (trigger) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_llc_sram_arb.sv
// Two-port round-robin arbiter in front of a single-port LLC SRAM macro with grant
// back-pressure lock and read-response routing. Scrub scheduling: AXI_LLC_SRAM_ARB_SCRUB_EN.
module axi_llc_sram_arb
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned ByteWidth   = 8,
  parameter int unsigned NumBanks    = 1,
  parameter int unsigned ScrubPeriod = 1024,
  localparam int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth    = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [ARB_NUM_PORTS-1:0]                 req_i,
  input  logic [ARB_NUM_PORTS-1:0]                 we_i,
  input  logic [ARB_NUM_PORTS-1:0][AddrWidth-1:0]  addr_i,
  input  logic [ARB_NUM_PORTS-1:0][DataWidth-1:0]  wdata_i,
  input  logic [ARB_NUM_PORTS-1:0][BeWidth-1:0]    be_i,
  output logic [ARB_NUM_PORTS-1:0]                 gnt_o,
  output logic [ARB_NUM_PORTS-1:0]                 rvalid_o,
  output logic [DataWidth-1:0]                     rdata_o,
  output logic                                     sram_req_o,
  output logic                                     sram_we_o,
  output logic [AddrWidth-1:0]                     sram_addr_o,
  output logic [DataWidth-1:0]                     sram_wdata_o,
  output logic [BeWidth-1:0]                       sram_be_o,
  input  logic                                     sram_gnt_i,
  input  logic [DataWidth-1:0]                     sram_rdata_i,
  output logic [NumBanks-1:0]                      scrub_trigger_o,
  output logic                                     busy_o
);

  port_idx_t sel;
  port_idx_t rr_q;
  port_idx_t lock_port_q;
  port_idx_t rd_owner_q;
  logic      lock_q;
  logic      rd_pend_q;
  logic      accept;

  // A stalled request stays pinned to its port so the macro sees a stable request.
  always_comb begin
    sel = arb_select(req_i, rr_q);
    if (lock_q) begin
      sel = lock_port_q;
    end
  end

  assign sram_req_o   = |req_i;
  assign sram_we_o    = we_i[sel];
  assign sram_addr_o  = addr_i[sel];
  assign sram_wdata_o = wdata_i[sel];
  assign sram_be_o    = be_i[sel];

  assign gnt_o[0] = sram_gnt_i & req_i[0] & (sel == 1'b0);
  assign gnt_o[1] = sram_gnt_i & req_i[1] & (sel == 1'b1);
  assign accept   = |gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_port_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
    end else begin
      if (accept) begin
        rr_q   <= ~sel;
        lock_q <= 1'b0;
      end else if (sram_req_o && !sram_gnt_i) begin
        lock_q      <= 1'b1;
        lock_port_q <= sel;
      end
      rd_pend_q <= accept & ~we_i[sel];
      if (accept) begin
        rd_owner_q <= sel;
      end
    end
  end

  assign rvalid_o[0] = rd_pend_q & (rd_owner_q == 1'b0);
  assign rvalid_o[1] = rd_pend_q & (rd_owner_q == 1'b1);
  assign rdata_o     = rd_pend_q ? sram_rdata_i : '0;
  assign busy_o      = accept | rd_pend_q;

`ifdef AXI_LLC_SRAM_ARB_SCRUB_EN
  logic scrub_pulse;

  axi_llc_scrub_sched #(
    .ScrubPeriod(ScrubPeriod)
  ) u_scrub_sched (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .idle   (~|req_i),
    .trigger(scrub_pulse)
  );

  assign scrub_trigger_o = {NumBanks{scrub_pulse}};
`else
  logic unused_scrub_cfg;
  assign unused_scrub_cfg = ^ScrubPeriod;
  assign scrub_trigger_o  = '0;
`endif

endmodule

// File: tb/tb_axi_llc_sram_arb.sv
// Directed bench for axi_llc_sram_arb: single read, contention, back-pressure lock,
// reset mid-read and scrub timing (ScrubPeriod = 8).
module tb_axi_llc_sram_arb;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 128;
  localparam int unsigned BW = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        req_i;
  logic [1:0]        we_i;
  logic [1:0][AW-1:0] addr_i;
  logic [1:0][DW-1:0] wdata_i;
  logic [1:0][BW-1:0] be_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              sram_req_o;
  logic              sram_we_o;
  logic [AW-1:0]     sram_addr_o;
  logic [DW-1:0]     sram_wdata_o;
  logic [BW-1:0]     sram_be_o;
  logic              sram_gnt_i;
  logic [DW-1:0]     sram_rdata_i;
  logic [0:0]        scrub_trigger_o;
  logic              busy_o;

  int checks   = 0;
  int failures = 0;

  axi_llc_sram_arb #(
    .NumWords   (1024),
    .DataWidth  (128),
    .ByteWidth  (8),
    .NumBanks   (1),
    .ScrubPeriod(8)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .we_i           (we_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .be_i           (be_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .sram_req_o     (sram_req_o),
    .sram_we_o      (sram_we_o),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .sram_be_o      (sram_be_o),
    .sram_gnt_i     (sram_gnt_i),
    .sram_rdata_i   (sram_rdata_i),
    .scrub_trigger_o(scrub_trigger_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A port stalled by macro back-pressure must hold its request until granted.
  logic [1:0] wait_q = 2'b00;
  always @(posedge clk_i) begin
    for (int p = 0; p < 2; p++) begin
      if (rst_ni && wait_q[p]) begin
        checks++;
        assert (req_i[p] === 1'b1) else begin
          failures++;
          $error("FAIL req_hold port=%0d observed=%0b expected=1", p, req_i[p]);
        end
      end
    end
    wait_q <= rst_ni ? (req_i & ~gnt_o & {2{~sram_gnt_i}}) : 2'b00;
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i  = 2'b00;
    we_i   = 2'b00;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] a5;
    logic [DW-1:0] pat;
    logic          exp_scrub;
    a5 = {16{8'hA5}};
    pat = {4{32'hC0FF_EE11}};
    rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    sram_gnt_i = 1'b1; sram_rdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_gnt", DW'(gnt_o), '0);
    chk("rst_rvalid", DW'(rvalid_o), '0);
    chk("rst_busy", DW'(busy_o), '0);
    chk("rst_scrub", DW'(scrub_trigger_o), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single read on port 1
    req_i = 2'b10; we_i = 2'b00; addr_i[1] = 10'h010;
    #1;
    chk("rd_gnt", DW'(gnt_o), DW'(2'b10));
    chk("rd_addr", DW'(sram_addr_o), DW'(10'h010));
    chk("rd_we", DW'(sram_we_o), '0);
    chk("rd_busy", DW'(busy_o), DW'(1'b1));
    @(negedge clk_i);
    req_i = 2'b00; sram_rdata_i = a5;
    #1;
    chk("rd_rvalid", DW'(rvalid_o), DW'(2'b10));
    chk("rd_rdata", rdata_o, a5);
    chk("rd_gnt_idle", DW'(gnt_o), '0);
    @(negedge clk_i);
    sram_rdata_i = '0;
    #1;
    chk("rd_rvalid_off", DW'(rvalid_o), '0);

    // Contention: alternating grants from reset, port 0 first
    do_reset();
    req_i = 2'b11; we_i = 2'b00; addr_i[0] = 10'h001; addr_i[1] = 10'h002;
    for (int k = 0; k < 6; k++) begin
      sram_rdata_i = DW'(k + 100);
      #1;
      chk($sformatf("ct_gnt%0d", k), DW'(gnt_o), (k % 2 == 1) ? DW'(2'b10) : DW'(2'b01));
      chk($sformatf("ct_addr%0d", k), DW'(sram_addr_o), (k % 2 == 1) ? DW'(10'h002) : DW'(10'h001));
      if (k > 0) begin
        chk($sformatf("ct_rvalid%0d", k), DW'(rvalid_o), (k % 2 == 1) ? DW'(2'b01) : DW'(2'b10));
        chk($sformatf("ct_rdata%0d", k), rdata_o, DW'(k + 100));
      end else begin
        chk("ct_rvalid0", DW'(rvalid_o), '0);
      end
      @(negedge clk_i);
    end
    req_i = 2'b00; sram_rdata_i = DW'(106);
    #1;
    chk("ct_rvalid6", DW'(rvalid_o), DW'(2'b10));
    chk("ct_rdata6", rdata_o, DW'(106));
    @(negedge clk_i);

    // Back-pressure lock: port 1 write stalls, port 0 read joins in the second cycle
    req_i = 2'b10; we_i = 2'b10; sram_gnt_i = 1'b0;
    addr_i[1] = 10'h03A; wdata_i[1] = pat; be_i[1] = 16'h00FF;
    addr_i[0] = 10'h055; wdata_i[0] = ~pat; be_i[0] = 16'hFFFF;
    #1;
    chk("lk_gnt0", DW'(gnt_o), '0);
    chk("lk_req0", DW'(sram_req_o), DW'(1'b1));
    chk("lk_addr0", DW'(sram_addr_o), DW'(10'h03A));
    @(negedge clk_i);
    req_i = 2'b11;
    #1;
    chk("lk_gnt1", DW'(gnt_o), '0);
    chk("lk_addr1", DW'(sram_addr_o), DW'(10'h03A));
    chk("lk_wdata1", sram_wdata_o, pat);
    chk("lk_be1", DW'(sram_be_o), DW'(16'h00FF));
    chk("lk_busy1", DW'(busy_o), '0);
    @(negedge clk_i);
    #1;
    chk("lk_gnt2", DW'(gnt_o), '0);
    chk("lk_we2", DW'(sram_we_o), DW'(1'b1));
    @(negedge clk_i);
    sram_gnt_i = 1'b1;
    #1;
    chk("lk_gnt3", DW'(gnt_o), DW'(2'b10));
    chk("lk_addr3", DW'(sram_addr_o), DW'(10'h03A));
    @(negedge clk_i);
    req_i = 2'b01;
    #1;
    chk("lk_gnt4", DW'(gnt_o), DW'(2'b01));
    chk("lk_addr4", DW'(sram_addr_o), DW'(10'h055));
    chk("lk_we4", DW'(sram_we_o), '0);
    chk("lk_norsp_wr", DW'(rvalid_o), '0);
    @(negedge clk_i);
    req_i = 2'b00; sram_rdata_i = pat;
    #1;
    chk("lk_rvalid5", DW'(rvalid_o), DW'(2'b01));
    chk("lk_rdata5", rdata_o, pat);
    @(negedge clk_i);

    // Reset asserted in the response cycle of an accepted read
    req_i = 2'b01; we_i = 2'b00; addr_i[0] = 10'h007;
    #1;
    chk("mr_gnt", DW'(gnt_o), DW'(2'b01));
    @(negedge clk_i);
    rst_ni = 1'b0; req_i = 2'b00; sram_rdata_i = {8{16'hDEAD}};
    #1;
    chk("mr_rst_rvalid", DW'(rvalid_o), '0);
    chk("mr_rst_rdata", rdata_o, '0);
    chk("mr_rst_gnt", DW'(gnt_o), '0);
    chk("mr_rst_busy", DW'(busy_o), '0);
    chk("mr_rst_sreq", DW'(sram_req_o), '0);
    chk("mr_rst_scrub", DW'(scrub_trigger_o), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("mr_post_rvalid%0d", k), DW'(rvalid_o), '0);
      @(negedge clk_i);
    end

    // Scrub timing: writes busy cycles 0-10, idle afterwards
    do_reset();
    we_i = 2'b01; sram_gnt_i = 1'b1;
    for (int k = 0; k < 24; k++) begin
      req_i = (k <= 10) ? 2'b01 : 2'b00;
`ifdef AXI_LLC_SRAM_ARB_SCRUB_EN
      exp_scrub = (k == 11) || (k == 16);
`else
      exp_scrub = 1'b0;
`endif
      #1;
      chk($sformatf("sc_trig%0d", k), DW'(scrub_trigger_o), DW'(exp_scrub));
      chk($sformatf("sc_busy%0d", k), DW'(busy_o), DW'(k <= 10));
      @(negedge clk_i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
